// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: FSM state type, op encodings and sizing constants for the shared fp add/sub arbiter
package fp_addsub_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = 4;
endpackage

// File: rtl/fp_rr_arb2.sv
// fp_rr_arb2: two-way round-robin grant (i_valid0/i_valid1/i_prio in, o_grant_valid/o_grant_id out); i_prio breaks ties
module fp_rr_arb2
  import fp_addsub_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_prio,
  output logic o_grant_valid,
  output logic o_grant_id
);
  assign o_grant_valid = i_valid0 | i_valid1;
  assign o_grant_id = (i_valid0 & i_valid1) ? i_prio : i_valid1;
endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: shares one fp add/sub datapath (dp_*) between two valid/ready requesters (req0/req1) with per-requester response channels (rsp0/rsp1)
module fp_addsub_arbiter
  import fp_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_op,
  input  logic [WIDTH-1:0] dp_result,
  output logic             busy
);
  state_t r_state, w_next;
  logic r_prio, r_owner, r_dp_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dp_a, r_dp_b, r_rsp_result;
  logic w_grant_valid, w_grant_id, w_accept, w_rsp_hs, w_cnt_zero;
  fp_rr_arb2 u_arb (
    .i_valid0      (req0_valid),
    .i_valid1      (req1_valid),
    .i_prio        (r_prio),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );
  // ready is gated by reset so no handshake is advertised while the block is held in reset
  assign w_accept = (r_state == IDLE) && w_grant_valid && !reset;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_rsp_hs = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);
  always_comb begin
    w_next = r_state;
    req0_ready = w_accept & ~w_grant_id;
    req1_ready = w_accept & w_grant_id;
    rsp0_valid = (r_state == RESP) & ~r_owner;
    rsp1_valid = (r_state == RESP) & r_owner;
    busy = (r_state != IDLE);
    w_next = (r_state == IDLE) ? (w_accept ? WAIT : IDLE) :
             (r_state == WAIT) ? (w_cnt_zero ? RESP : WAIT) :
             (w_rsp_hs ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= 1'b0;
      r_owner <= 1'b0;
      r_cnt <= '0;
      r_dp_a <= '0;
      r_dp_b <= '0;
      r_dp_op <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_dp_a <= w_grant_id ? req1_a : req0_a;
        r_dp_b <= w_grant_id ? req1_b : req0_b;
        r_dp_op <= w_grant_id ? req1_op : req0_op;
        r_owner <= w_grant_id;
        r_cnt <= CNT_W'(LATENCY);
      end
      // WAIT spans LATENCY+1 edges; the result is taken on the edge that sees the counter at zero
      if (r_state == WAIT) begin
        r_cnt <= w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        if (w_cnt_zero) r_rsp_result <= dp_result;
      end
      if (w_rsp_hs) r_prio <= ~r_owner;
    end
  end
  assign dp_a = r_dp_a;
  assign dp_b = r_dp_b;
  assign dp_op = r_dp_op;
  assign rsp_result = r_rsp_result;
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: directed-vector check of the arbiter at LATENCY 1 and LATENCY 3 with table-driven datapath models
module tb_fp_addsub_arbiter;
  import fp_addsub_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, dp_op, busy;
  logic [31:0] rsp_result, dp_a, dp_b, dp_result;
  logic req0_valid_3, req0_ready_3, req0_op_3, req1_valid_3, req1_ready_3, req1_op_3;
  logic [31:0] req0_a_3, req0_b_3, req1_a_3, req1_b_3;
  logic rsp0_valid_3, rsp0_ready_3, rsp1_valid_3, rsp1_ready_3, dp_op_3, busy_3;
  logic [31:0] rsp_result_3, dp_a_3, dp_b_3, dp_result_3, p1_3, p2_3;
  int n_chk = 0;
  int n_err = 0;
  int n_acc, last, seen;
  always #5 clk = ~clk;
  fp_addsub_arbiter #(.WIDTH(32), .LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_result(dp_result), .busy(busy)
  );
  fp_addsub_arbiter #(.WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid_3), .req0_ready(req0_ready_3), .req0_a(req0_a_3), .req0_b(req0_b_3), .req0_op(req0_op_3),
    .req1_valid(req1_valid_3), .req1_ready(req1_ready_3), .req1_a(req1_a_3), .req1_b(req1_b_3), .req1_op(req1_op_3),
    .rsp0_valid(rsp0_valid_3), .rsp0_ready(rsp0_ready_3), .rsp1_valid(rsp1_valid_3), .rsp1_ready(rsp1_ready_3),
    .rsp_result(rsp_result_3), .dp_a(dp_a_3), .dp_b(dp_b_3), .dp_op(dp_op_3), .dp_result(dp_result_3), .busy(busy_3)
  );
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == OP_ADD) return 32'h40400000;
    if (a == 32'h40A00000 && b == 32'h40400000 && op == OP_SUB) return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'h3F800000 && op == OP_ADD) return 32'h40000000;
    if (a == 32'h40400000 && b == 32'h3F800000 && op == OP_SUB) return 32'h40000000;
    return 32'hFFFFFFFF;
  endfunction
  always @(posedge clk) dp_result <= fp_model(dp_a, dp_b, dp_op);
  always @(posedge clk) begin
    p1_3 <= fp_model(dp_a_3, dp_b_3, dp_op_3);
    p2_3 <= p1_3;
    dp_result_3 <= p2_3;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    {req0_valid, req0_op, req1_valid, req1_op, rsp0_ready, rsp1_ready} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    {req0_valid_3, req0_op_3, req1_valid_3, req1_op_3, rsp0_ready_3, rsp1_ready_3} = '0;
    {req0_a_3, req0_b_3, req1_a_3, req1_b_3} = '0;
    req0_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_v0", rsp0_valid, 0);
    chk("rst_v1", rsp1_valid, 0);
    chk("rst_dpa", dp_a, 0);
    chk("rst_res", rsp_result, 0);
    @(negedge clk); reset = 1'b0; req0_valid = 1'b0;
    // single add on requester 0
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = OP_ADD; rsp0_ready = 1; #1;
    chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    @(negedge clk); req0_valid = 0; #1;
    chk("t1_busy", busy, 1);
    chk("t1_v0_c1", rsp0_valid, 0);
    chk("t1_dpa", dp_a, 32'h3F800000);
    chk("t1_dpb", dp_b, 32'h40000000);
    @(negedge clk); #1;
    chk("t1_v0_c2", rsp0_valid, 0);
    @(negedge clk); #1;
    chk("t1_v0", rsp0_valid, 1);
    chk("t1_v1", rsp1_valid, 0);
    chk("t1_res", rsp_result, 32'h40400000);
    @(negedge clk); #1;
    chk("t1_idle", busy, 0);
    chk("t1_v0_off", rsp0_valid, 0);
    rsp0_ready = 0;
    reset = 1; #1; reset = 0;
    // contention with prio 0: requester 0 first, then requester 1
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h40A00000; req0_b = 32'h40400000; req0_op = OP_SUB;
    req1_valid = 1; req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_op = OP_ADD;
    rsp0_ready = 1; rsp1_ready = 1; #1;
    chk("t2_rdy0", req0_ready, 1);
    chk("t2_rdy1", req1_ready, 0);
    @(negedge clk); req0_valid = 0; #1;
    chk("t2_wait_rdy1", req1_ready, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t2_v0", rsp0_valid, 1);
    chk("t2_res0", rsp_result, 32'h40000000);
    chk("t2_v1_off", rsp1_valid, 0);
    chk("t2_hs_rdy1", req1_ready, 0);
    @(negedge clk); #1;
    chk("t2_rdy1b", req1_ready, 1);
    @(negedge clk); req1_valid = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t2_v1", rsp1_valid, 1);
    chk("t2_res1", rsp_result, 32'h40000000);
    chk("t2_v0_off", rsp0_valid, 0);
    @(negedge clk); #1;
    chk("t2_idle", busy, 0);
    // both requesters continuously: strict alternation starting with 0, spacing 4
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = OP_ADD;
    req1_valid = 1; req1_a = 32'h40A00000; req1_b = 32'h40400000; req1_op = OP_SUB; #1;
    n_acc = 0; last = 0;
    for (int c = 0; c < 40 && n_acc < 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (rsp0_valid) chk("t3_res0", rsp_result, 32'h40400000);
      if (rsp1_valid) chk("t3_res1", rsp_result, 32'h40000000);
      if (req0_ready | req1_ready) begin
        chk("t3_gid", req1_ready, n_acc % 2);
        if (n_acc > 0) chk("t3_gap", c - last, 4);
        last = c;
        n_acc++;
      end
    end
    chk("t3_nacc", n_acc, 6);
    @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
    for (int t = 0; t < 20 && busy; t++) begin @(negedge clk); #1; end
    chk("t3_idle", busy, 0);
    // response backpressure on requester 1 while requester 0 waits
    rsp1_ready = 0;
    @(negedge clk);
    req1_valid = 1; req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_op = OP_ADD; #1;
    chk("t4_rdy1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0; req1_a = 32'h12345678;
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = OP_ADD; #1;
    chk("t4_rdy0_w", req0_ready, 0);
    @(negedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t4_v1", rsp1_valid, 1);
      chk("t4_res", rsp_result, 32'h40000000);
      chk("t4_v0", rsp0_valid, 0);
      chk("t4_rdy0", req0_ready, 0);
    end
    @(negedge clk); rsp1_ready = 1; #1;
    chk("t4_hs_rdy0", req0_ready, 0);
    @(negedge clk); #1;
    chk("t4_v1_off", rsp1_valid, 0);
    chk("t4_rdy0b", req0_ready, 1);
    rsp1_ready = 0; rsp0_ready = 1;
    @(negedge clk); req0_valid = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t4_v0b", rsp0_valid, 1);
    chk("t4_res0", rsp_result, 32'h40400000);
    @(negedge clk); #1;
    chk("t4_idle", busy, 0);
    // reset during WAIT drops the operation
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = OP_ADD; #1;
    chk("t5_rdy0", req0_ready, 1);
    @(negedge clk); req0_valid = 0; #1;
    chk("t5_busy_pre", busy, 1);
    reset = 1; #1;
    chk("t5_busy", busy, 0);
    chk("t5_dpa", dp_a, 0);
    chk("t5_dpb", dp_b, 0);
    chk("t5_res", rsp_result, 0);
    @(negedge clk); reset = 0; #1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (rsp0_valid | rsp1_valid | busy) seen++;
    end
    chk("t5_no_rsp", seen, 0);
    @(negedge clk); req0_valid = 1; #1;
    chk("t5_rdy0b", req0_ready, 1);
    @(negedge clk); req0_valid = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t5_v0", rsp0_valid, 1);
    chk("t5_res0", rsp_result, 32'h40400000);
    @(negedge clk); #1;
    rsp0_ready = 0;
    // LATENCY 3 instance with a three-stage datapath model
    @(negedge clk);
    req0_valid_3 = 1; req0_a_3 = 32'h40400000; req0_b_3 = 32'h3F800000; req0_op_3 = OP_SUB; rsp0_ready_3 = 1; #1;
    chk("t6_rdy0", req0_ready_3, 1);
    @(negedge clk); req0_valid_3 = 0; req0_a_3 = 32'hDEADBEEF; req0_b_3 = 32'h0; req0_op_3 = OP_ADD; #1;
    for (int k = 1; k <= 4; k++) begin
      chk("t6_v0_wait", rsp0_valid_3, 0);
      chk("t6_dpa", dp_a_3, 32'h40400000);
      chk("t6_dpb", dp_b_3, 32'h3F800000);
      chk("t6_dpop", dp_op_3, OP_SUB);
      @(negedge clk); #1;
    end
    chk("t6_v0", rsp0_valid_3, 1);
    chk("t6_res", rsp_result_3, 32'h40000000);
    chk("t6_dpa_end", dp_a_3, 32'h40400000);
    @(negedge clk); #1;
    chk("t6_idle", busy_3, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
